// File: rtl/credit_rr_sched_pkg.sv
// ============================================================================
// Module      : sched_pkg
// Description : Shared types and width helpers for the credit RR scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sched_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} sched_state_t;

  localparam int unsigned c_NUM_REQS_DEF    = 4;
  localparam int unsigned c_MAX_CREDITS_DEF = 4;
  localparam int unsigned c_BURST_DEF       = 2;
  localparam int unsigned c_CWID_DEF        = $clog2(c_MAX_CREDITS_DEF + 1);
  localparam int unsigned c_PTR_W_DEF       = $clog2(c_NUM_REQS_DEF);

  function automatic int unsigned cwid_of(input int unsigned max_credits);
    return $clog2(max_credits + 1);
  endfunction

  function automatic int unsigned ptr_w_of(input int unsigned num_reqs);
    return (num_reqs < 2) ? 1 : $clog2(num_reqs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/credit_rr_sched_if.sv
// ============================================================================
// Module      : credit_rr_sched_if
// Description : Request/grant/credit bundle between FIFO bank and scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface credit_rr_sched_if
  import sched_pkg::*;
#(
  parameter int unsigned NUM_REQS = c_NUM_REQS_DEF,
  parameter int unsigned CWID     = c_CWID_DEF
);
  localparam int unsigned c_PW = ptr_w_of(NUM_REQS);

  logic [NUM_REQS-1:0] reqs;
  logic                blk;
  logic                credit_ret;
  logic [NUM_REQS-1:0] gnt;
  logic [CWID-1:0]     credits;
  logic [c_PW-1:0]     holder;
  logic                err;

  modport master (
    output reqs, blk, credit_ret,
    input  gnt, credits, holder, err
  );

  modport slave (
    input  reqs, blk, credit_ret,
    output gnt, credits, holder, err
  );

endinterface

`default_nettype wire

// File: rtl/credit_rr_sched_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker starting at 'start'.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import sched_pkg::*;
#(
  parameter int unsigned NUM_REQS = c_NUM_REQS_DEF,
  parameter int unsigned PW       = ptr_w_of(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] reqs,
  input  logic [PW-1:0]       start,
  output logic [NUM_REQS-1:0] sel,
  output logic [PW-1:0]       idx,
  output logic                any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    sel    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < int'(NUM_REQS); k++) begin
      w_cand = PW'((int'(start) + k) % int'(NUM_REQS));
      if (!any && reqs[w_cand]) begin
        any         = 1'b1;
        sel[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/credit_rr_sched.sv
// ============================================================================
// Module      : credit_rr_sched
// Description : Credit-gated round-robin scheduler with burst hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_rr_sched
  import sched_pkg::*;
#(
  parameter int unsigned NUM_REQS    = c_NUM_REQS_DEF,
  parameter int unsigned MAX_CREDITS = c_MAX_CREDITS_DEF,
  parameter int unsigned BURST       = c_BURST_DEF,
  parameter int unsigned CWID        = cwid_of(MAX_CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  credit_rr_sched_if.slave  bus
);

  localparam int unsigned      c_PW        = ptr_w_of(NUM_REQS);
  localparam int unsigned      c_BW        = $clog2(BURST + 1);
  localparam logic [c_PW-1:0]  c_LAST      = c_PW'(NUM_REQS - 1);
  localparam logic [c_BW-1:0]  c_BURST_END = c_BW'(BURST);
  localparam logic [CWID-1:0]  c_CRED_MAX  = CWID'(MAX_CREDITS);

  sched_state_t        r_state;
  logic [c_PW-1:0]     r_ptr;
  logic [c_PW-1:0]     r_holder;
  logic [c_BW-1:0]     r_bcnt;
  logic [CWID-1:0]     r_credits;
  logic                r_err;

  logic                w_can_grant;
  logic                w_hold_keep;
  logic                w_any;
  logic                w_granted;
  logic [c_PW-1:0]     w_holder_inc;
  logic [c_PW-1:0]     w_start;
  logic [c_PW-1:0]     w_idx;
  logic [c_PW-1:0]     w_idx_inc;
  logic [c_BW-1:0]     w_bcnt_inc;
  logic [NUM_REQS-1:0] w_sel;
  logic [NUM_REQS-1:0] w_holder_oh;
  logic [NUM_REQS-1:0] w_gnt;

  assign w_can_grant  = !rst && !bus.blk && (r_credits != '0);
  assign w_hold_keep  = (r_state == HOLD) && bus.reqs[r_holder];
  assign w_holder_inc = (r_holder == c_LAST) ? '0 : r_holder + c_PW'(1);
  assign w_idx_inc    = (w_idx == c_LAST) ? '0 : w_idx + c_PW'(1);
  assign w_bcnt_inc   = r_bcnt + c_BW'(1);
  assign w_holder_oh  = NUM_REQS'(1) << r_holder;

  // A releasing holder re-arbitrates from its successor in the same cycle.
  assign w_start = (r_state == HOLD) ? w_holder_inc : r_ptr;

  rr_pick #(
    .NUM_REQS (NUM_REQS),
    .PW       (c_PW)
  ) u_pick (
    .reqs  (bus.reqs),
    .start (w_start),
    .sel   (w_sel),
    .idx   (w_idx),
    .any   (w_any)
  );

  always_comb begin
    w_gnt = '0;
    if (w_can_grant) begin
      w_gnt = w_hold_keep ? w_holder_oh : w_sel;
    end
  end

  assign w_granted = |w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_holder <= '0;
      r_bcnt   <= '0;
    end else if (w_can_grant) begin
      if (w_hold_keep) begin
        r_bcnt <= w_bcnt_inc;
        if (w_bcnt_inc == c_BURST_END) begin
          r_state <= IDLE;
          r_ptr   <= w_holder_inc;
        end
      end else if (w_any) begin
        if (BURST == 1) begin
          r_state <= IDLE;
          r_ptr   <= w_idx_inc;
        end else begin
          r_state  <= HOLD;
          r_holder <= w_idx;
          r_bcnt   <= c_BW'(1);
        end
      end else if (r_state == HOLD) begin
        r_state <= IDLE;
        r_ptr   <= w_holder_inc;
      end
    end
  end

  // Credits track returns even while blocked; a return into a full counter is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= c_CRED_MAX;
      r_err     <= 1'b0;
    end else if (w_granted && !bus.credit_ret) begin
      r_credits <= r_credits - CWID'(1);
    end else if (!w_granted && bus.credit_ret) begin
      if (r_credits == c_CRED_MAX) begin
        r_err <= 1'b1;
      end else begin
        r_credits <= r_credits + CWID'(1);
      end
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.credits = r_credits;
  assign bus.holder  = r_holder;
  assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_credit_rr_sched.sv
// ============================================================================
// Module      : tb_credit_rr_sched
// Description : Scoreboard bench for credit_rr_sched against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_credit_rr_sched;
  import sched_pkg::*;

  localparam int N    = 4;
  localparam int MAXC = 4;
  localparam int B    = 2;
  localparam int CW   = 3;

  logic clk;
  logic rst;

  credit_rr_sched_if #(.NUM_REQS(N), .CWID(CW)) bus ();

  credit_rr_sched #(
    .NUM_REQS    (N),
    .MAX_CREDITS (MAXC),
    .BURST       (B),
    .CWID        (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    int           cred;
    bit           err;
    bit           hv;
    int           holder;
  } exp_t;

  exp_t  sb[$];
  int    obs[$];
  bit    rec;
  int    checks;
  int    errors;
  string phase;

  // Reference state: who holds the port, grants taken so far, RR start, credits.
  bit m_hold;
  int m_holder;
  int m_cnt;
  int m_ptr;
  int m_cred;
  bit m_err;

  int exp_burst[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_early[5] = '{0, 0, 1, 2, 2};

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic model(input logic [N-1:0] r, input bit b, input bit cr, input bit rs);
    exp_t e;
    int   win;
    int   start;
    bit   can;
    if (rs) begin
      m_hold = 0; m_holder = 0; m_cnt = 0; m_ptr = 0; m_cred = MAXC; m_err = 0;
      e.gnt = '0; e.cred = MAXC; e.err = 0; e.hv = 1; e.holder = 0;
      sb.push_back(e);
      return;
    end
    e.cred = m_cred; e.err = m_err; e.hv = m_hold; e.holder = m_holder;
    can = !b && (m_cred > 0);
    win = -1;
    if (can) begin
      if (m_hold && bit_at(r, m_holder)) begin
        win = m_holder;
      end else begin
        start = m_hold ? (m_holder + 1) % N : m_ptr;
        for (int k = 0; k < N; k++)
          if (win < 0 && bit_at(r, (start + k) % N)) win = (start + k) % N;
      end
    end
    e.gnt = (win >= 0) ? (N'(1) << win) : '0;
    sb.push_back(e);
    if (can) begin
      if (m_hold && bit_at(r, m_holder)) begin
        m_cnt++;
        if (m_cnt == B) begin m_hold = 0; m_ptr = (m_holder + 1) % N; end
      end else if (win >= 0) begin
        if (B == 1) m_ptr = (win + 1) % N;
        else begin m_hold = 1; m_holder = win; m_cnt = 1; end
      end else if (m_hold) begin
        m_hold = 0; m_ptr = (m_holder + 1) % N;
      end
    end
    if (win >= 0 && !cr) m_cred--;
    else if (win < 0 && cr) begin
      if (m_cred == MAXC) m_err = 1;
      else m_cred++;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input bit b, input bit cr, input bit rs);
    @(negedge clk);
    rst = rs; bus.reqs = r; bus.blk = b; bus.credit_ret = cr;
    model(r, b, cr, rs);
  endtask

  // Monitor: pops one expected record per presented cycle and compares.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== e.gnt) begin
          errors++;
          $display("FAIL gnt [%s] t=%0t got %b expected %b", phase, $time, bus.gnt, e.gnt);
        end
        checks++;
        if (int'(bus.credits) != e.cred) begin
          errors++;
          $display("FAIL credits [%s] t=%0t got %0d expected %0d", phase, $time, bus.credits, e.cred);
        end
        checks++;
        if (bus.err !== e.err) begin
          errors++;
          $display("FAIL err [%s] t=%0t got %b expected %b", phase, $time, bus.err, e.err);
        end
        if (e.hv) begin
          checks++;
          if (int'(bus.holder) != e.holder) begin
            errors++;
            $display("FAIL holder [%s] t=%0t got %0d expected %0d", phase, $time, bus.holder, e.holder);
          end
        end
        if (rec) begin
          for (int i = 0; i < N; i++)
            if (bit_at(bus.gnt, i)) obs.push_back(i);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] cur;
    checks = 0; errors = 0; rec = 0; phase = "reset";
    rst = 1'b1; bus.reqs = '0; bus.blk = 1'b0; bus.credit_ret = 1'b0;
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0);

    phase = "exhaust"; obs.delete(); rec = 1;
    repeat (6) step(4'b0001, 0, 0, 0);
    #3;
    checks++;
    if (obs.size() != 4) begin
      errors++; $display("FAIL exhaust_count got %0d expected 4", obs.size());
    end
    step(4'b0001, 0, 1, 0);
    repeat (3) step(4'b0001, 0, 0, 0);
    #3;
    checks++;
    if (obs.size() != 5) begin
      errors++; $display("FAIL return_grant got %0d expected 5", obs.size());
    end
    rec = 0;

    phase = "burst";
    step(4'b0000, 0, 0, 1);
    obs.delete(); rec = 1;
    step(4'b1111, 0, 0, 0);
    repeat (8) step(4'b1111, 0, 1, 0);
    #3; rec = 0;
    checks++;
    if (obs.size() != 9) begin
      errors++; $display("FAIL burst_len got %0d expected 9", obs.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (obs[i] != exp_burst[i]) begin
          errors++; $display("FAIL burst_order[%0d] got %0d expected %0d", i, obs[i], exp_burst[i]);
        end
      end
    end

    phase = "early";
    step(4'b0000, 0, 0, 1);
    obs.delete(); rec = 1;
    repeat (3) step(4'b1111, 0, 1, 0);
    repeat (2) step(4'b1101, 0, 1, 0);
    #3; rec = 0;
    checks++;
    if (obs.size() != 5) begin
      errors++; $display("FAIL early_len got %0d expected 5", obs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs[i] != exp_early[i]) begin
          errors++; $display("FAIL early_order[%0d] got %0d expected %0d", i, obs[i], exp_early[i]);
        end
      end
    end

    phase = "credits";
    step(4'b0000, 0, 0, 1);
    repeat (3) step(4'b0001, 0, 0, 0);
    step(4'b0001, 0, 1, 0);
    repeat (4) step(4'b0000, 0, 1, 0);
    repeat (2) step(4'b0000, 0, 0, 0);
    #3;
    checks++;
    if (bus.err !== 1'b1 || int'(bus.credits) != MAXC) begin
      errors++; $display("FAIL overflow got err=%b credits=%0d expected err=1 credits=%0d", bus.err, bus.credits, MAXC);
    end

    phase = "blk";
    step(4'b0000, 0, 0, 1);
    step(4'b0010, 0, 0, 0);
    repeat (2) step(4'b0010, 1, 0, 0);
    repeat (2) step(4'b0010, 0, 0, 0);
    step(4'b0010, 1, 1, 0);

    phase = "rst_mid";
    step(4'b0000, 0, 0, 1);
    step(4'b1111, 0, 0, 0);
    repeat (2) step(4'b1111, 0, 0, 1);
    repeat (2) step(4'b1111, 0, 0, 0);

    phase = "random";
    cur = 4'b1111;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 30) cur = N'($urandom_range(0, (1 << N) - 1));
      step(cur, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 45,
           $urandom_range(0, 199) < 1);
    end

    phase = "drain";
    repeat (2) step(4'b0000, 0, 0, 0);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
